// File: rtl/quantizer_arbiter_if.sv
// Bundle between quantizer_arbiter and its neighbours: the requester side,
// the shared quantizer side and the return (response) side.
//
// Handshake rule for every valid/ready pair on this bus: a beat moves on a
// rising clk edge where valid and ready are both 1. A producer holds valid
// and its data stable until that edge. Ready may depend on state only; the
// arbiter never derives a ready from the valid it is paired with.
interface quantizer_arbiter_if #(
  parameter int NUM_REQ        = 2,
  parameter int IN_WIDTH       = 16,
  parameter int IN_SIZE        = 4,
  parameter int IN_PARALLELISM = 1,
  parameter int OUT_WIDTH      = 8,
  parameter int MAX_NUM_WIDTH  = 16
);
  localparam int E    = IN_SIZE * IN_PARALLELISM;
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ*E-1:0][IN_WIDTH-1:0] req_data_in;
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [E-1:0][IN_WIDTH-1:0]         q_data_in;
  logic                               q_data_in_valid;
  logic                               q_data_in_ready;
  logic [E-1:0][OUT_WIDTH-1:0]        q_data_out;
  logic [MAX_NUM_WIDTH-1:0]           q_max_num;
  logic                               q_data_out_valid;
  logic                               q_data_out_ready;
  logic [E-1:0][OUT_WIDTH-1:0]        resp_data_out;
  logic [MAX_NUM_WIDTH-1:0]           resp_max_num;
  logic [ID_W-1:0]                    resp_id;
  logic [NUM_REQ-1:0]                 resp_valid;
  logic [NUM_REQ-1:0]                 resp_ready;

  // Arbiter side.
  modport slave (
    input  req_data_in, req_valid, q_data_in_ready, q_data_out, q_max_num,
           q_data_out_valid, resp_ready,
    output req_ready, q_data_in, q_data_in_valid, q_data_out_ready,
           resp_data_out, resp_max_num, resp_id, resp_valid
  );

  // Environment side: requesters plus the quantizer.
  modport master (
    output req_data_in, req_valid, q_data_in_ready, q_data_out, q_max_num,
           q_data_out_valid, resp_ready,
    input  req_ready, q_data_in, q_data_in_valid, q_data_out_ready,
           resp_data_out, resp_max_num, resp_id, resp_valid
  );
endinterface

// File: rtl/quantizer_arbiter.sv
// Round-robin burst arbiter sharing one quantizer between NUM_REQ requesters.
// An ID FIFO remembers the owner of every beat inside the quantizer so each
// result is steered back to the requester that issued it, in issue order.
// Optional feature macro: QUANT_ARB_STATS_EN adds per-requester wait counters
// on output stat_wait_cycles.
module quantizer_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int IN_WIDTH       = 16,
  parameter int IN_SIZE        = 4,
  parameter int IN_PARALLELISM = 1,
  parameter int OUT_WIDTH      = 8,
  parameter int MAX_NUM_WIDTH  = 16,
  parameter int BURST_LEN      = 4,
  parameter int TAG_DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  quantizer_arbiter_if.slave        bus,
  output logic                      fsm_state
`ifdef QUANT_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]  stat_wait_cycles
`endif
);
  localparam int E     = IN_SIZE * IN_PARALLELISM;
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int AW    = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int OCC_W = $clog2(TAG_DEPTH + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               q_valid_c;
  logic               accept;

  logic [ID_W-1:0]    id_mem [TAG_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [OCC_W-1:0]   occ, occ_d;
  logic               fifo_full_q;
  logic               fifo_empty;
  logic [ID_W-1:0]    head;
  logic               pop;

  logic [E-1:0][IN_WIDTH-1:0]  q_tile;
  logic [E-1:0][OUT_WIDTH-1:0] resp_tile;
  logic [MAX_NUM_WIDTH-1:0]    resp_max;

  function automatic logic [AW-1:0] ptr_inc(logic [AW-1:0] p);
    return (p == AW'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    int cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!pick_found && bus.req_valid[ID_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = ID_W'(cand);
      end
    end
  end

  // FSM next state and handshake outputs; IDLE spends one cycle arbitrating.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    req_ready_c = '0;
    q_valid_c   = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        q_valid_c            = bus.req_valid[grant_q] & ~fifo_full_q;
        req_ready_c[grant_q] = bus.q_data_in_ready & ~fifo_full_q;
        accept               = bus.req_valid[grant_q] & req_ready_c[grant_q];
        if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
        // Burst ends on its last beat, or as soon as the owner stops asking.
        if ((accept && (beat_cnt_q == CNT_W'(BURST_LEN - 1))) || !bus.req_valid[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and arbitration registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= ID_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Forward mux: granted requester's tile goes straight to the quantizer.
  always_comb begin
    q_tile = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant_q == ID_W'(r)) q_tile = bus.req_data_in[r*E +: E];
    end
  end

  assign bus.q_data_in       = q_tile;
  assign bus.q_data_in_valid = q_valid_c;
  assign bus.req_ready       = req_ready_c;
  assign fsm_state           = (state_q == BURST);

  // Return path: owner of the oldest in-flight beat sits at the FIFO head.
  assign fifo_empty = (occ == '0);
  assign head       = id_mem[rd_ptr];
  assign pop        = bus.q_data_out_valid & bus.q_data_out_ready;

  assign bus.q_data_out_ready = ~fifo_empty & bus.resp_ready[head];
  assign bus.resp_id          = fifo_empty ? '0 : head;
  assign resp_tile            = bus.q_data_out;
  assign resp_max             = bus.q_max_num;
  assign bus.resp_data_out    = resp_tile;
  assign bus.resp_max_num     = resp_max;

  // One-hot result valid towards the owner only.
  always_comb begin
    bus.resp_valid = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      bus.resp_valid[k] = bus.q_data_out_valid & ~fifo_empty & (head == ID_W'(k));
    end
  end

  // Occupancy after this cycle's push/pop; both may happen together.
  always_comb begin
    occ_d = occ;
    case ({accept, pop})
      2'b10:   occ_d = occ + 1'b1;
      2'b01:   occ_d = occ - 1'b1;
      default: occ_d = occ;
    endcase
  end

  // ID FIFO pointers; full is registered so a same-cycle pop cannot free a slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      fifo_full_q <= 1'b0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      occ         <= occ_d;
      fifo_full_q <= (occ_d == OCC_W'(TAG_DEPTH));
    end
  end

  // ID FIFO storage; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (accept) id_mem[wr_ptr] <= grant_q;
  end

`ifdef QUANT_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] wait_q;

  // Saturating count of cycles each requester asks without being accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (bus.req_valid[r] && !(accept && (grant_q == ID_W'(r))) && (wait_q[r] != 16'hFFFF))
          wait_q[r] <= wait_q[r] + 16'd1;
      end
    end
  end

  assign stat_wait_cycles = wait_q;
`endif
endmodule

// File: tb/tb_quantizer_arbiter.sv
// Directed bench for quantizer_arbiter with a behavioural quantizer model.
// Expected results are queued when stimulus is loaded; a negedge monitor
// pops and compares every result handed back to a requester.
module tb_quantizer_arbiter;
  localparam int NUM_REQ        = 2;
  localparam int IN_WIDTH       = 16;
  localparam int IN_SIZE        = 4;
  localparam int IN_PARALLELISM = 1;
  localparam int OUT_WIDTH      = 8;
  localparam int MAX_NUM_WIDTH  = 16;
  localparam int BURST_LEN      = 4;
  localparam int TAG_DEPTH      = 4;
  localparam int EXP_W          = 1 + 16 + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  quantizer_arbiter_if #(
    .NUM_REQ(NUM_REQ), .IN_WIDTH(IN_WIDTH), .IN_SIZE(IN_SIZE),
    .IN_PARALLELISM(IN_PARALLELISM), .OUT_WIDTH(OUT_WIDTH), .MAX_NUM_WIDTH(MAX_NUM_WIDTH)
  ) bus ();

  logic fsm_state;
`ifdef QUANT_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] stat_wait_cycles;
`endif

  quantizer_arbiter #(
    .NUM_REQ(NUM_REQ), .IN_WIDTH(IN_WIDTH), .IN_SIZE(IN_SIZE),
    .IN_PARALLELISM(IN_PARALLELISM), .OUT_WIDTH(OUT_WIDTH), .MAX_NUM_WIDTH(MAX_NUM_WIDTH),
    .BURST_LEN(BURST_LEN), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .fsm_state(fsm_state)
`ifdef QUANT_ARB_STATS_EN
    ,
    .stat_wait_cycles(stat_wait_cycles)
`endif
  );

  // ---------------- bench state ----------------
  logic [63:0]      src0_q[$];
  logic [63:0]      src1_q[$];
  logic [47:0]      qpipe[$];
  logic [EXP_W-1:0] exp_q[$];
  logic [1:0]       resp_rdy = 2'b11;
  logic             q_in_rdy = 1'b1;
  int               acc_cnt  = 0;
  int               n_checks = 0;
  int               n_pass   = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Tile for requester id, sequence seq: elements id*64+seq*4+i, all in int8 range.
  function automatic logic [63:0] tile_of(int id, int seq);
    logic [63:0] t;
    for (int i = 0; i < 4; i++) t[i*16 +: 16] = 16'(id*64 + seq*4 + i);
    return t;
  endfunction

  // Hand-derived result for tile_of(id, seq): data = elements, max = element 3.
  function automatic logic [EXP_W-1:0] exp_of(int id, int seq);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) d[i*8 +: 8] = 8'(id*64 + seq*4 + i);
    return {1'(id), 16'(id*64 + seq*4 + 3), d};
  endfunction

  // Quantizer model: max |x| and symmetric saturation to int8.
  function automatic logic [47:0] quant_model(logic [63:0] t);
    logic [15:0]        mx;
    logic [31:0]        d;
    logic signed [15:0] v;
    logic [15:0]        a;
    mx = '0;
    d  = '0;
    for (int i = 0; i < 4; i++) begin
      v = t[i*16 +: 16];
      a = v[15] ? 16'(-v) : v;
      if (a > mx) mx = a;
      if (v > 127)       d[i*8 +: 8] = 8'h7F;
      else if (v < -127) d[i*8 +: 8] = 8'h81;
      else               d[i*8 +: 8] = v[7:0];
    end
    return {mx, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive();
    logic [63:0] t0, t1;
    t0 = (src0_q.size() != 0) ? src0_q[0] : 64'h0;
    t1 = (src1_q.size() != 0) ? src1_q[0] : 64'h0;
    bus.req_valid        = {src1_q.size() != 0, src0_q.size() != 0};
    bus.req_data_in      = {t1, t0};
    bus.q_data_in_ready  = q_in_rdy;
    bus.q_data_out_valid = (qpipe.size() != 0);
    {bus.q_max_num, bus.q_data_out} = (qpipe.size() != 0) ? qpipe[0] : 48'h0;
    bus.resp_ready       = resp_rdy;
  endtask

  // One clock: sample handshakes at negedge, apply them just after posedge.
  task automatic step();
    logic        a0, a1, qa, qp;
    logic [63:0] qt, tmp;
    logic [47:0] tq;
    @(negedge clk);
    a0 = bus.req_valid[0] & bus.req_ready[0];
    a1 = bus.req_valid[1] & bus.req_ready[1];
    qa = bus.q_data_in_valid & bus.q_data_in_ready;
    qp = bus.q_data_out_valid & bus.q_data_out_ready;
    qt = bus.q_data_in;
    @(posedge clk);
    #1;
    if (rst) begin
      if (a0 && src0_q.size() != 0) tmp = src0_q.pop_front();
      if (a1 && src1_q.size() != 0) tmp = src1_q.pop_front();
      if (qp && qpipe.size() != 0)  tq  = qpipe.pop_front();
      if (qa) begin
        qpipe.push_back(quant_model(qt));
        acc_cnt++;
      end
    end
    drive();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    src0_q.delete();
    src1_q.delete();
    qpipe.delete();
    exp_q.delete();
    drive();
    repeat (3) step();
    rst = 1'b1;
    drive();
    #1;
  endtask

  task automatic drain(int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src0_q.size() != 0 || src1_q.size() != 0) && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (rst === 1'b1 && bus.resp_valid != '0) begin
      chk("resp_onehot_owner", 64'(bus.resp_valid), 64'(2'b01 << bus.resp_id));
      if (bus.resp_valid[bus.resp_id] && bus.resp_ready[bus.resp_id]) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_id", 64'(bus.resp_id), 64'(e[48]));
          chk("resp_max_num", 64'(bus.resp_max_num), 64'(e[47:32]));
          chk("resp_data_out", 64'(bus.resp_data_out), 64'(e[31:0]));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    drive();

    // Power-on reset, then start a burst and reset it midway.
    resp_rdy = 2'b00;
    do_reset();
    for (int s = 0; s < 4; s++) src0_q.push_back(tile_of(0, s));
    drive();
    repeat (3) step();
    chk("midburst_accepts", 64'(acc_cnt), 64'd2);

    rst = 1'b0;
    resp_rdy = 2'b11;
    qpipe.delete();
    exp_q.delete();
    qpipe.push_back(48'h00AA_1234_5678);
    drive();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_q_in_valid", 64'(bus.q_data_in_valid), 64'd0);
      chk("rst_q_out_ready", 64'(bus.q_data_out_ready), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_resp_id", 64'(bus.resp_id), 64'd0);
      chk("rst_fsm_idle", 64'(fsm_state), 64'd0);
    end
    rst = 1'b1;
    src0_q.delete();
    drive();
    // Stray quantizer output with an empty ID FIFO must be held, not consumed.
    repeat (2) step();
    chk("empty_hold_q_out_ready", 64'(bus.q_data_out_ready), 64'd0);
    chk("empty_hold_resp_valid", 64'(bus.resp_valid), 64'd0);
    qpipe.delete();
    drive();

    // Both requesters always valid: 0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1.
    acc_cnt = 0;
    for (int s = 0; s < 8; s++) begin
      src0_q.push_back(tile_of(0, s));
      src1_q.push_back(tile_of(1, s));
    end
    for (int blk = 0; blk < 2; blk++)
      for (int id = 0; id < 2; id++)
        for (int s = 0; s < 4; s++) exp_q.push_back(exp_of(id, blk*4 + s));
    drive();
    step();
    chk("rr_idle_first", 64'(acc_cnt), 64'd0);
    repeat (4) step();
    chk("rr_burst0_len", 64'(acc_cnt), 64'd4);
    step();
    chk("rr_bubble", 64'(acc_cnt), 64'd4);
    step();
    chk("rr_burst1_start", 64'(acc_cnt), 64'd5);
    drain(200);

    // Requester 1 offers two beats then drops: early release, then requester 0.
    do_reset();
    acc_cnt = 0;
    for (int s = 0; s < 2; s++) begin
      src1_q.push_back(tile_of(1, s));
      exp_q.push_back(exp_of(1, s));
    end
    drive();
    step();
    for (int s = 0; s < 3; s++) begin
      src0_q.push_back(tile_of(0, s));
      exp_q.push_back(exp_of(0, s));
    end
    drive();
    repeat (3) step();
    chk("early_rel_beats", 64'(acc_cnt), 64'd2);
    step();
    chk("early_rel_idle", 64'(acc_cnt), 64'd2);
    step();
    chk("early_rel_next", 64'(acc_cnt), 64'd3);
    drain(200);

    // Results blocked: exactly TAG_DEPTH beats in flight, single pop frees one slot late.
    do_reset();
    acc_cnt  = 0;
    resp_rdy = 2'b00;
    for (int s = 0; s < 6; s++) begin
      src0_q.push_back(tile_of(0, s));
      exp_q.push_back(exp_of(0, s));
    end
    drive();
    repeat (10) step();
    chk("full_accepts", 64'(acc_cnt), 64'(TAG_DEPTH));
    chk("full_req_ready", 64'(bus.req_ready), 64'd0);
    resp_rdy = 2'b01;
    drive();
    step();
    resp_rdy = 2'b00;
    drive();
    chk("full_pop_no_push", 64'(acc_cnt), 64'd4);
    step();
    chk("full_push_after_pop", 64'(acc_cnt), 64'd5);
    repeat (3) step();
    chk("full_again", 64'(acc_cnt), 64'd5);
    resp_rdy = 2'b11;
    drive();
    drain(200);

    // +3/-127 tile from requester 1 next to an ordinary beat from requester 0.
    do_reset();
    src0_q.push_back(tile_of(0, 0));
    exp_q.push_back(exp_of(0, 0));
    src1_q.push_back({16'hFF81, 16'h0003, 16'hFF81, 16'h0003});
    exp_q.push_back({1'b1, 16'h007F, 32'h8103_8103});
    drive();
    drain(200);

`ifdef QUANT_ARB_STATS_EN
    // Requester 1 joins one cycle into requester 0's arbitration and waits 5 cycles.
    do_reset();
    for (int s = 0; s < 4; s++) begin
      src0_q.push_back(tile_of(0, s));
      exp_q.push_back(exp_of(0, s));
    end
    drive();
    step();
    src1_q.push_back(tile_of(1, 0));
    exp_q.push_back(exp_of(1, 0));
    drive();
    drain(200);
    chk("stat_wait_req1", 64'(stat_wait_cycles[1]), 64'd5);
    chk("stat_wait_req0", 64'(stat_wait_cycles[0]), 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
